// File: rtl/biquad8_coeff_loader.sv
// Coefficient shadow store and reverse-order replay sequencer for the biquad8 notch chain.
// Host writes land in a shadow; a commit streams them onto the chain bus and pulses update.
module biquad8_coeff_loader #(
    parameter int unsigned WR_HOLD = 16,
    parameter int unsigned GAP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  host_adr_i,
    input  logic [17:0] host_dat_i,
    input  logic        host_wr_i,
    output logic [17:0] host_rd_dat_o,
    output logic        host_err_o,
    input  logic        commit_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  coeff_adr_o,
    output logic [17:0] coeff_dat_o,
    output logic        coeff_wr_o,
    output logic        coeff_update_o
);
    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 18;
    localparam int unsigned NCOEF    = 23;
    localparam int unsigned IW       = 5;
    localparam int unsigned CNT_MAX  = (WR_HOLD > GAP) ? WR_HOLD : GAP;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_GAP, S_UPDATE
    } state_t;

    // Shadow slots are stored in replay order: slot i is the i-th coefficient sent.
    function automatic logic [AW-1:0] slot_adr(input logic [IW-1:0] s);
        if (s <= IW'(8))       return AW'(24) - AW'(s);
        else if (s <= IW'(16)) return AW'(16) - AW'(s);
        else if (s <= IW'(20)) return AW'(52) - AW'(s);
        else                   return AW'(70) - AW'(s);
    endfunction

    // Returns {mapped, slot} for a chain address.
    function automatic logic [IW:0] adr_slot(input logic [AW-1:0] a);
        if (a >= AW'(16) && a <= AW'(24)) return {1'b1, IW'(AW'(24) - a)};
        if (a <= AW'(7))                  return {1'b1, IW'(AW'(16) - a)};
        if (a >= AW'(32) && a <= AW'(35)) return {1'b1, IW'(AW'(52) - a)};
        if (a == AW'(48) || a == AW'(49)) return {1'b1, IW'(AW'(70) - a)};
        return '0;
    endfunction

    logic [DW-1:0] shadow_q [NCOEF];
    logic [DW-1:0] rd_dat_q;
    logic          err_q;
    logic          host_map_c;
    logic [IW-1:0] host_slot_c;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          upd_q;
    logic          wr_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;

    assign {host_map_c, host_slot_c} = adr_slot(host_adr_i);

    // Host port: writes only while idle; error pulse on busy or unmapped write.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '{default: '0};
            rd_dat_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q    <= host_wr_i && (busy_q || !host_map_c);
            rd_dat_q <= host_map_c ? shadow_q[host_slot_c] : '0;
            if (host_wr_i && !busy_q && host_map_c) begin
                shadow_q[host_slot_c] <= host_dat_i;
            end
        end
    end

    // Replay sequencer; LOAD samples the shadow at the end of its clock so a
    // same-edge write with commit is already visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (commit_i) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    adr_q   <= slot_adr(idx_q);
                    dat_q   <= shadow_q[idx_q];
                    wr_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (cnt_q == CW'(WR_HOLD - 1)) begin
                        wr_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CW'(GAP - 1)) begin
                        cnt_q <= '0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_UPDATE;
                            upd_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= S_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_UPDATE: begin
                    upd_q   <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign host_rd_dat_o  = rd_dat_q;
    assign host_err_o     = err_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign coeff_adr_o    = adr_q;
    assign coeff_dat_o    = dat_q;
    assign coeff_wr_o     = wr_q;
    assign coeff_update_o = upd_q;
endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader: host port vectors, random writes,
// and replay sequences compared against an address-indexed shadow model.
module tb_biquad8_coeff_loader;
    localparam int unsigned WR_HOLD  = 16;
    localparam int unsigned GAP      = 1;
    localparam int          SEQ_CLKS = 23 * (WR_HOLD + GAP + 1) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  host_adr_i = '0;
    logic [17:0] host_dat_i = '0;
    logic        host_wr_i = 1'b0;
    logic [17:0] host_rd_dat_o;
    logic        host_err_o;
    logic        commit_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  coeff_adr_o;
    logic [17:0] coeff_dat_o;
    logic        coeff_wr_o;
    logic        coeff_update_o;

    always #5 clk = ~clk;

    biquad8_coeff_loader #(.WR_HOLD(WR_HOLD), .GAP(GAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_adr_i    (host_adr_i),
        .host_dat_i    (host_dat_i),
        .host_wr_i     (host_wr_i),
        .host_rd_dat_o (host_rd_dat_o),
        .host_err_o    (host_err_o),
        .commit_i      (commit_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .coeff_adr_o   (coeff_adr_o),
        .coeff_dat_o   (coeff_dat_o),
        .coeff_wr_o    (coeff_wr_o),
        .coeff_update_o(coeff_update_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] shad [256];
    logic [7:0]  order [$];

    typedef struct {
        logic [7:0]  adr;
        logic [17:0] dat;
        logic        wr;
        logic        exp_err;
        logic [17:0] exp_rd;
    } vec_t;
    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [7:0] a);
        return (a <= 8'd7) || (a >= 8'd16 && a <= 8'd24) || (a >= 8'd32 && a <= 8'd35) ||
               (a == 8'd48) || (a == 8'd49);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int a = 0; a < 256; a++) shad[a] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; commit_i = 1'b0; host_wr_i = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        clear_model();
    endtask

    // One idle-time host access; read data reflects contents before this write.
    task automatic host_op(input string tag, input logic [7:0] adr, input logic [17:0] dat, input logic wr);
        logic [17:0] exp_rd;
        logic        exp_err;
        exp_rd  = is_mapped(adr) ? shad[adr] : 18'h0;
        exp_err = wr && !is_mapped(adr);
        host_adr_i = adr; host_dat_i = dat; host_wr_i = wr;
        step();
        host_wr_i = 1'b0;
        check({tag, " err"}, 32'(host_err_o), 32'(exp_err));
        check({tag, " rd"}, 32'(host_rd_dat_o), 32'(exp_rd));
        if (wr && is_mapped(adr)) shad[adr] = dat;
    endtask

    // Commit and watch the whole replay; optional second commit at mid_c and a
    // rejected host write at bw_c (cycle index from the first busy clock).
    task automatic run_replay(input string tag, input bit with_wr, input logic [7:0] wadr,
                              input logic [17:0] wdat, input int mid_c, input int bw_c);
        logic [7:0]  badr [$];
        logic [17:0] bdat [$];
        int          blen [$];
        int          glen [$];
        int busy_cnt = 0, upd_cnt = 0, upd_c = -1, done_bad = 0, unstable = 0;
        int run = 0, low = 0, err_c = -1, gap_bad = 0;
        bit prev_wr = 1'b0, seen_first = 1'b0, finished = 1'b0;
        logic [7:0]  cur_adr = '0;
        logic [17:0] cur_dat = '0;

        commit_i = 1'b1;
        if (with_wr) begin
            host_adr_i = wadr; host_dat_i = wdat; host_wr_i = 1'b1;
            if (is_mapped(wadr)) shad[wadr] = wdat;
        end
        step();
        commit_i = 1'b0; host_wr_i = 1'b0;

        for (int c = 0; c < SEQ_CLKS + 50; c++) begin
            if (c == 0) check({tag, " busy rise"}, 32'(busy_o), 32'd1);
            if (c == err_c) check({tag, " busy write err"}, 32'(host_err_o), 32'd1);
            if (coeff_update_o !== done_o) done_bad++;
            if (coeff_update_o) begin upd_cnt++; upd_c = c; end
            if (busy_o) busy_cnt++;
            if (coeff_wr_o) begin
                if (!prev_wr) begin
                    badr.push_back(coeff_adr_o); bdat.push_back(coeff_dat_o);
                    cur_adr = coeff_adr_o; cur_dat = coeff_dat_o; run = 0;
                    if (seen_first) glen.push_back(low);
                    seen_first = 1'b1;
                end else if (coeff_adr_o !== cur_adr || coeff_dat_o !== cur_dat) begin
                    unstable++;
                end
                run++;
            end else begin
                if (prev_wr) begin blen.push_back(run); low = 0; end
                low++;
            end
            prev_wr = coeff_wr_o;
            if (!busy_o) begin finished = 1'b1; break; end
            commit_i = (c == mid_c);
            if (c == bw_c) begin
                host_adr_i = 8'd0; host_dat_i = 18'h15555; host_wr_i = 1'b1; err_c = c + 1;
            end else begin
                host_wr_i = 1'b0;
            end
            step();
        end
        commit_i = 1'b0; host_wr_i = 1'b0;

        check({tag, " finished"}, 32'(finished), 32'd1);
        check({tag, " busy clks"}, 32'(busy_cnt), 32'(SEQ_CLKS));
        check({tag, " update count"}, 32'(upd_cnt), 32'd1);
        check({tag, " update cycle"}, 32'(upd_c), 32'(SEQ_CLKS - 1));
        check({tag, " done!=update"}, 32'(done_bad), 32'd0);
        check({tag, " adr/dat unstable"}, 32'(unstable), 32'd0);
        check({tag, " bursts"}, 32'(badr.size()), 32'd23);
        for (int i = 0; i < 23 && i < badr.size(); i++) begin
            check($sformatf("%s burst%0d adr", tag, i), 32'(badr[i]), 32'(order[i]));
            check($sformatf("%s burst%0d dat", tag, i), 32'(bdat[i]), 32'(shad[order[i]]));
            if (i < blen.size()) check($sformatf("%s burst%0d len", tag, i), 32'(blen[i]), 32'(WR_HOLD));
        end
        foreach (glen[i]) if (glen[i] != GAP + 1) gap_bad++;
        check({tag, " gap lengths"}, 32'(gap_bad), 32'd0);
        check({tag, " idle wr"}, 32'(coeff_wr_o), 32'd0);
        check({tag, " idle adr hold"}, 32'(coeff_adr_o), 32'(order[22]));
        check({tag, " idle dat hold"}, 32'(coeff_dat_o), 32'(shad[order[22]]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, run, hit, stray;
        bit prev;

        for (int a = 24; a >= 16; a--) order.push_back(8'(a));
        for (int a = 7; a >= 0; a--)   order.push_back(8'(a));
        for (int a = 35; a >= 32; a--) order.push_back(8'(a));
        order.push_back(8'd49); order.push_back(8'd48);

        vecs = '{
            '{8'd10,  18'h01234, 1'b1, 1'b1, 18'h0},
            '{8'd60,  18'h00abc, 1'b1, 1'b1, 18'h0},
            '{8'd10,  18'h0,     1'b0, 1'b0, 18'h0},
            '{8'd60,  18'h0,     1'b0, 1'b0, 18'h0},
            '{8'd5,   18'h2AAAA, 1'b1, 1'b0, 18'h0},
            '{8'd5,   18'h0,     1'b0, 1'b0, 18'h2AAAA},
            '{8'd49,  18'h3FFFF, 1'b1, 1'b0, 18'h0},
            '{8'd49,  18'h00007, 1'b1, 1'b0, 18'h3FFFF},
            '{8'd49,  18'h0,     1'b0, 1'b0, 18'h00007},
            '{8'd35,  18'h00001, 1'b1, 1'b0, 18'h0},
            '{8'd35,  18'h0,     1'b0, 1'b0, 18'h00001},
            '{8'd8,   18'h00005, 1'b1, 1'b1, 18'h0},
            '{8'd15,  18'h00005, 1'b1, 1'b1, 18'h0},
            '{8'd36,  18'h00005, 1'b1, 1'b1, 18'h0},
            '{8'd16,  18'h00010, 1'b1, 1'b0, 18'h0},
            '{8'd16,  18'h0,     1'b0, 1'b0, 18'h00010},
            '{8'd200, 18'h0,     1'b0, 1'b0, 18'h0}
        };

        // Reset state
        do_reset();
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset wr", 32'(coeff_wr_o), 32'd0);
        check("reset update", 32'(coeff_update_o), 32'd0);
        check("reset adr", 32'(coeff_adr_o), 32'd0);
        check("reset dat", 32'(coeff_dat_o), 32'd0);
        check("reset err", 32'(host_err_o), 32'd0);
        host_op("rd0", 8'd0, 18'h0, 1'b0);
        host_op("rd24", 8'd24, 18'h0, 1'b0);
        host_op("rd49", 8'd49, 18'h0, 1'b0);

        // Host port vector table
        foreach (vecs[i]) begin
            host_adr_i = vecs[i].adr; host_dat_i = vecs[i].dat; host_wr_i = vecs[i].wr;
            step();
            host_wr_i = 1'b0;
            check($sformatf("vec%0d err", i), 32'(host_err_o), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d rd", i), 32'(host_rd_dat_o), 32'(vecs[i].exp_rd));
            if (vecs[i].wr && is_mapped(vecs[i].adr)) shad[vecs[i].adr] = vecs[i].dat;
        end

        // Full replay with value = addr<<4 and a rejected write while busy
        do_reset();
        foreach (order[i]) host_op("seed", order[i], 18'(order[i]) << 4, 1'b1);
        run_replay("seq", 1'b0, 8'd0, 18'h0, -1, 50);
        host_op("post rd0", 8'd0, 18'h0, 1'b0);
        host_op("post rd24", 8'd24, 18'h0, 1'b0);

        // Second commit mid-sequence, write during the update clock
        run_replay("recommit", 1'b0, 8'd0, 18'h0, 200, SEQ_CLKS - 1);

        // Random host traffic then replay
        for (int i = 0; i < 80; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
            host_op($sformatf("rand%0d", i), a, 18'($urandom), 1'($urandom_range(0, 1)));
        end
        run_replay("rand", 1'b0, 8'd0, 18'h0, -1, -1);

        // Reset during the fifth burst, eighth write clock
        commit_i = 1'b1; step(); commit_i = 1'b0;
        nb = 0; run = 0; hit = 0; prev = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (coeff_wr_o) begin
                if (!prev) begin nb++; run = 0; end
                run++;
            end
            prev = coeff_wr_o;
            if (nb == 5 && run == 8) begin hit = 1; break; end
            step();
        end
        check("abort point reached", 32'(hit), 32'd1);
        rst = 1'b1;
        step();
        check("abort wr", 32'(coeff_wr_o), 32'd0);
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort update", 32'(coeff_update_o), 32'd0);
        check("abort adr", 32'(coeff_adr_o), 32'd0);
        check("abort dat", 32'(coeff_dat_o), 32'd0);
        step();
        rst = 1'b0;
        clear_model();
        stray = 0;
        for (int c = 0; c < SEQ_CLKS + 20; c++) begin
            if (coeff_update_o || coeff_wr_o || busy_o) stray++;
            step();
        end
        check("abort no activity", 32'(stray), 32'd0);
        host_op("abort rd24", 8'd24, 18'h0, 1'b0);
        host_op("abort rd0", 8'd0, 18'h0, 1'b0);
        host_op("abort rd48", 8'd48, 18'h0, 1'b0);

        // Same-edge write and commit: replay carries the new value
        do_reset();
        run_replay("same-edge", 1'b1, 8'd24, 18'h3FFFF, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
